// File: rtl/bank_dma.sv
// bank_dma: background copy sequencer between two bank64k banks.
// Reads cmd_len words from the source bank's rdc port and writes them in
// ascending order to the destination bank's wrc port. The block uses only the
// lowest-priority channel, so every request can be refused by the grant and
// must then be held unchanged until it is granted.
//
// Optional feature macro: BANK_DMA_ABORT_EN
//   defined   -> an 'abort' input exists; abort in RUN drops the command at once
//   undefined -> no abort port; every accepted command runs to completion
module bank_dma #(
  parameter int w = 128,
  parameter int a = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [a-1:0] cmd_src,
  input  logic [a-1:0] cmd_dst,
  input  logic [a:0]   cmd_len,
  output logic         rd_csel,
  output logic         rd_en,
  output logic [a-1:0] rd_addr,
  input  logic [w-1:0] rd_word,
  input  logic         rd_grnt,
  output logic         wr_csel,
  output logic         wr_en,
  output logic [a-1:0] wr_addr,
  output logic [w-1:0] wr_word,
  input  logic         wr_grnt,
  output logic         busy,
  output logic         done
`ifdef BANK_DMA_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [a-1:0] PTR_ONE = 1;
  localparam logic [a:0]   CNT_ONE = 1;

  state_t         state;

  logic [a-1:0]   src_ptr;
  logic [a-1:0]   dst_ptr;
  logic [a:0]     len_q;
  logic [a:0]     rd_issued;
  logic [a:0]     wr_count;

  logic           inflight;
  logic [w-1:0]   fifo_mem [2];
  logic           fifo_head;
  logic           fifo_tail;
  logic [1:0]     fifo_count;
  logic           fifo_empty;
  logic [1:0]     occupancy;

  logic           cmd_fire;
  logic           rd_fire;
  logic           wr_fire;
  logic           push;
  logic           pop;
  logic           abort_hit;

  // Abort only has an effect while a copy is actually running.
`ifdef BANK_DMA_ABORT_EN
  assign abort_hit = abort & (state == RUN);
`else
  assign abort_hit = 1'b0;
`endif

  // Commands are taken only in IDLE and never while reset is held.
  assign cmd_ready = (state == IDLE) & ~rst;
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Words owed to the write side: buffered ones plus the read whose data
  // arrives this cycle. Reads stop once that reaches the buffer depth.
  assign fifo_empty = (fifo_count == 2'd0);
  assign occupancy  = fifo_count + {1'b0, inflight};

  // Read request: held steady while refused because nothing it depends on can
  // change without a grant.
  assign rd_en   = (state == RUN) & (rd_issued < len_q) & (occupancy < 2'd2);
  assign rd_csel = rd_en;
  assign rd_addr = src_ptr;
  assign rd_fire = rd_en & rd_grnt;

  // Write request: the buffer head, or the word arriving from the bank this
  // cycle when the buffer is empty, so a granted stream flows at 1 word/cycle.
  assign wr_en   = (state == RUN) & (~fifo_empty | inflight);
  assign wr_csel = wr_en;
  assign wr_addr = dst_ptr;
  assign wr_word = fifo_empty ? rd_word : fifo_mem[fifo_head];
  assign wr_fire = wr_en & wr_grnt;

  // A captured word goes into the buffer unless it is written straight through.
  assign push = inflight & ~(fifo_empty & wr_fire);
  assign pop  = wr_fire & ~fifo_empty;

  // Control FSM. A zero-length command also passes through RUN: the count
  // check there is already satisfied, so it moves to FIN without any bank
  // access. The completion check uses the registered write count, so FIN
  // follows the cycle after the last write commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_fire) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wr_count == len_q) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Address pointers and progress counters; pointers wrap naturally at 2^a.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      len_q     <= '0;
      rd_issued <= '0;
      wr_count  <= '0;
    end else if (cmd_fire) begin
      src_ptr   <= cmd_src;
      dst_ptr   <= cmd_dst;
      len_q     <= cmd_len;
      rd_issued <= '0;
      wr_count  <= '0;
    end else begin
      if (rd_fire) begin
        src_ptr   <= src_ptr + PTR_ONE;
        rd_issued <= rd_issued + CNT_ONE;
      end
      if (wr_fire) begin
        dst_ptr  <= dst_ptr + PTR_ONE;
        wr_count <= wr_count + CNT_ONE;
      end
    end
  end

  // Read-return tracking and buffer bookkeeping; reset and abort both forget
  // the pending read and everything buffered.
  always_ff @(posedge clk) begin
    if (rst || abort_hit) begin
      inflight   <= 1'b0;
      fifo_head  <= 1'b0;
      fifo_tail  <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight <= rd_fire;
      if (push) begin
        fifo_tail <= ~fifo_tail;
      end
      if (pop) begin
        fifo_head <= ~fifo_head;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Buffer storage; stale entries are harmless because the count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_tail] <= rd_word;
    end
  end

endmodule

// File: tb/tb_bank_dma.sv
// tb_bank_dma: directed self-checking bench for bank_dma.
// Models the source bank (1-cycle read latency) and destination bank around
// the DUT and checks copy data, addresses, timing, reset and grant stalls.
module tb_bank_dma;

  localparam int W = 128;
  localparam int A = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [A-1:0]   cmd_src;
  logic [A-1:0]   cmd_dst;
  logic [A:0]     cmd_len;
  logic           rd_csel;
  logic           rd_en;
  logic [A-1:0]   rd_addr;
  logic [W-1:0]   rd_word;
  logic           rd_grnt;
  logic           wr_csel;
  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_word;
  logic           wr_grnt;
  logic           busy;
  logic           done;
`ifdef BANK_DMA_ABORT_EN
  logic           abort;
`endif

  logic [W-1:0]   src_mem [512];
  logic [W-1:0]   dst_mem [512];
  logic [A-1:0]   wr_log [$];
  logic [A-1:0]   rd_log [$];

  int             outstanding;
  int             max_out;
  int             hold_viol;
  int             csel_viol;
  logic           p_rd_en, p_rd_grnt, p_wr_en, p_wr_grnt, p_rst;
  logic [A-1:0]   p_rd_addr, p_wr_addr;
  logic [W-1:0]   p_wr_word;

  int             errorCount = 0;
  int             checkCount = 0;
  int             dk, fw, bn, en_cnt;
  logic [A-1:0]   a9;

  always #5 clk = ~clk;

  bank_dma #(.w(W), .a(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .rd_csel   (rd_csel),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_word   (rd_word),
    .rd_grnt   (rd_grnt),
    .wr_csel   (wr_csel),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_word   (wr_word),
    .wr_grnt   (wr_grnt),
    .busy      (busy),
    .done      (done)
`ifdef BANK_DMA_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Distinct, recognisable content for every source address.
  function automatic logic [W-1:0] pat(input logic [A-1:0] x);
    return {{23'h2AB5C3, x}, {23'h15A3C0, x}, {23'h7FFFFF, x}, {23'h000001, x}};
  endfunction

  // Bank models: source returns data one cycle after a granted read, and
  // returns junk otherwise so stale captures show up.
  always @(posedge clk) begin
    if (rd_en && rd_grnt) begin
      rd_word <= src_mem[rd_addr];
      rd_log.push_back(rd_addr);
    end else begin
      rd_word <= 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    end
    if (wr_en && wr_grnt) begin
      dst_mem[wr_addr] <= wr_word;
      wr_log.push_back(wr_addr);
    end
  end

  // Protocol watcher: words owed (granted reads minus granted writes), held
  // requests while refused, and csel tracking en.
  always @(posedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (rd_en && rd_grnt) outstanding++;
      if (wr_en && wr_grnt) outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (!rst && !p_rst) begin
      if (p_rd_en && !p_rd_grnt && (!rd_en || rd_addr != p_rd_addr)) hold_viol++;
      if (p_wr_en && !p_wr_grnt && (!wr_en || wr_addr != p_wr_addr || wr_word != p_wr_word))
        hold_viol++;
      if (rd_csel !== rd_en || wr_csel !== wr_en) csel_viol++;
    end
    p_rst     = rst;
    p_rd_en   = rd_en;
    p_rd_grnt = rd_grnt;
    p_rd_addr = rd_addr;
    p_wr_en   = wr_en;
    p_wr_grnt = wr_grnt;
    p_wr_addr = wr_addr;
    p_wr_word = wr_word;
  end

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one command, then follow it cycle by cycle (k = cycles after the
  // accepting cycle) until done or until stop_writes words have committed.
  // mode 0: grants always on; 1: rd grant on odd cycles, wr refused k=6..10;
  // 2: grants on, plus a stray cmd_valid at k=3 that must be ignored.
  task automatic applyStimulus(input logic [A-1:0] src, input logic [A-1:0] dst,
                               input logic [A:0] len, input int mode, input int stop_writes,
                               output int done_k, output int first_wr_k,
                               output int busy_n, output int en_n);
    int k;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_valid = 1'b1;
    checkOutput("accept_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid  = 1'b0;
    done_k     = -1;
    first_wr_k = -1;
    busy_n     = 0;
    en_n       = 0;
    k          = 1;
    while (k < 300) begin
      if (stop_writes > 0 && wr_log.size() >= stop_writes) break;
      if (mode == 1) begin
        rd_grnt = k[0];
        wr_grnt = !(k >= 6 && k <= 10);
      end else begin
        rd_grnt = 1'b1;
        wr_grnt = 1'b1;
      end
      if (mode == 2 && k == 3) begin
        cmd_valid = 1'b1;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = 10'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (busy) busy_n++;
      if (rd_en || wr_en) en_n++;
      if (wr_en && first_wr_k < 0) first_wr_k = k;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    rd_grnt   = 1'b1;
    wr_grnt   = 1'b1;
    if (stop_writes > 0) checkOutput("stop_reached", wr_log.size() >= stop_writes, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    for (int i = 0; i < 512; i++) begin
      src_mem[i] = pat(A'(i));
      dst_mem[i] = '0;
    end
    max_out   = 0;
    hold_viol = 0;
    csel_viol = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    rd_grnt   = 1'b1;
    wr_grnt   = 1'b1;
`ifdef BANK_DMA_ABORT_EN
    abort     = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",   cmd_ready, 1'b0);
    checkOutput("rst_busy",    busy,      1'b0);
    checkOutput("rst_done",    done,      1'b0);
    checkOutput("rst_rd_en",   rd_en,     1'b0);
    checkOutput("rst_wr_en",   wr_en,     1'b0);
    checkOutput("rst_rd_csel", rd_csel,   1'b0);
    checkOutput("rst_wr_csel", wr_csel,   1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", cmd_ready, 1'b1);

    // Test 1: len=4, 0x010 -> 0x100, with a stray command while busy
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h010, 9'h100, 10'd4, 2, 0, dk, fw, bn, en_cnt);
    checkOutput("t1_first_wr", fw, 7'd2);
    checkOutput("t1_done_cycle", dk, 7'd7);
    checkOutput("t1_busy_cycles", bn, 7'd7);
    checkOutput("t1_nwrites", wr_log.size(), 7'd4);
    for (int i = 0; i < 4; i++) begin
      a9 = A'(32'h100 + i);
      checkOutput("t1_wr_addr", wr_log[i], a9);
      checkOutput("t1_data", dst_mem[a9], pat(A'(32'h010 + i)));
    end
    @(negedge clk);
    checkOutput("t1_after_busy",  busy,      1'b0);
    checkOutput("t1_after_done",  done,      1'b0);
    checkOutput("t1_after_ready", cmd_ready, 1'b1);

    // Test 2: zero-length command
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h005, 9'h006, 10'd0, 0, 0, dk, fw, bn, en_cnt);
    checkOutput("t2_done_cycle", dk, 7'd2);
    checkOutput("t2_busy_cycles", bn, 7'd2);
    checkOutput("t2_no_access", en_cnt, 7'd0);
    checkOutput("t2_nwrites", wr_log.size() + rd_log.size(), 7'd0);
    @(negedge clk);
    checkOutput("t2_after_ready", cmd_ready, 1'b1);

    // Test 3: address wrap on both sides
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h1FE, 9'h1FF, 10'd3, 0, 0, dk, fw, bn, en_cnt);
    checkOutput("t3_done_cycle", dk, 7'd6);
    checkOutput("t3_nreads", rd_log.size(), 7'd3);
    checkOutput("t3_nwrites", wr_log.size(), 7'd3);
    checkOutput("t3_rd0", rd_log[0], 9'h1FE);
    checkOutput("t3_rd1", rd_log[1], 9'h1FF);
    checkOutput("t3_rd2", rd_log[2], 9'h000);
    checkOutput("t3_wr0", wr_log[0], 9'h1FF);
    checkOutput("t3_wr1", wr_log[1], 9'h000);
    checkOutput("t3_wr2", wr_log[2], 9'h001);
    checkOutput("t3_data0", dst_mem[9'h1FF], pat(9'h1FE));
    checkOutput("t3_data1", dst_mem[9'h000], pat(9'h1FF));
    checkOutput("t3_data2", dst_mem[9'h001], pat(9'h000));
    @(negedge clk);

    // Test 4: refused grants on both sides, len=16
    wr_log.delete();
    rd_log.delete();
    max_out   = 0;
    hold_viol = 0;
    applyStimulus(9'h020, 9'h180, 10'd16, 1, 0, dk, fw, bn, en_cnt);
    checkOutput("t4_done_seen", dk > 0, 1'b1);
    checkOutput("t4_nwrites", wr_log.size(), 7'd16);
    for (int i = 0; i < 16; i++) begin
      a9 = A'(32'h180 + i);
      checkOutput("t4_wr_addr", wr_log[i], a9);
      checkOutput("t4_data", dst_mem[a9], pat(A'(32'h020 + i)));
    end
    checkOutput("t4_max_outstanding", max_out, 7'd2);
    checkOutput("t4_held_while_refused", hold_viol, 7'd0);
    checkOutput("csel_equals_en", csel_viol, 7'd0);
    @(negedge clk);

    // Test 5: reset in the middle of a copy, then a clean short copy
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h040, 9'h0C0, 10'd8, 0, 3, dk, fw, bn, en_cnt);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_rd_en", rd_en,     1'b0);
    checkOutput("t5_rst_wr_en", wr_en,     1'b0);
    checkOutput("t5_rst_busy",  busy,      1'b0);
    checkOutput("t5_rst_done",  done,      1'b0);
    checkOutput("t5_rst_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_post_ready", cmd_ready, 1'b1);
    checkOutput("t5_post_wr_en", wr_en, 1'b0);
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h060, 9'h0E0, 10'd2, 0, 0, dk, fw, bn, en_cnt);
    checkOutput("t5_done_cycle", dk, 7'd5);
    checkOutput("t5_nwrites", wr_log.size(), 7'd2);
    checkOutput("t5_wr0", wr_log[0], 9'h0E0);
    checkOutput("t5_wr1", wr_log[1], 9'h0E1);
    checkOutput("t5_data0", dst_mem[9'h0E0], pat(9'h060));
    checkOutput("t5_data1", dst_mem[9'h0E1], pat(9'h061));
    @(negedge clk);

`ifdef BANK_DMA_ABORT_EN
    // Test 6: abort after two committed writes
    wr_log.delete();
    rd_log.delete();
    applyStimulus(9'h080, 9'h140, 10'd8, 0, 2, dk, fw, bn, en_cnt);
    abort   = 1'b1;
    wr_grnt = 1'b0;
    @(negedge clk);
    abort   = 1'b0;
    wr_grnt = 1'b1;
    checkOutput("t6_ready", cmd_ready, 1'b1);
    checkOutput("t6_busy",  busy,      1'b0);
    checkOutput("t6_rd_en", rd_en,     1'b0);
    checkOutput("t6_wr_en", wr_en,     1'b0);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) en_cnt++;
      @(negedge clk);
    end
    checkOutput("t6_no_done", en_cnt, 7'd0);
    checkOutput("t6_nwrites", wr_log.size(), 7'd2);
    checkOutput("t6_data1", dst_mem[9'h141], pat(9'h081));
    checkOutput("t6_untouched", dst_mem[9'h142], 128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
